// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MULWAIT/MEM/WB sequencer with multiply latency and memory timeout
module multicycle_controller #(
  parameter int MUL_CYCLES  = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       run_i,
  input  logic [5:0] op_i,
  input  logic [5:0] fcn_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       alu_src_o,
  output logic       alu_src2_o,
  output logic       reg_sl_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic [3:0] alu_op_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       mem_to_reg_o,
  output logic       brnch_o,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       busy_o,
  output logic       err_o
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam int MW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MULWAIT, MEM, WB} state_t;

  state_t        state_q, state_d, done_st;
  logic [5:0]    op_q, op_d, fcn_q, fcn_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [MW-1:0] mul_q, mul_d;
  logic          err_q, err_d;
  logic          r_type, s_type, is_lw, is_sw, is_bne, is_mul, is_shift, is_imm, legal, tmo_hit, ctl_en;
  logic [3:0]    alu_op_dec;

  assign r_type   = op_q == 6'h00;
  assign s_type   = op_q == 6'h1C;
  assign is_lw    = op_q == 6'h23;
  assign is_sw    = op_q == 6'h2B;
  assign is_bne   = op_q == 6'h05;
  assign is_mul   = s_type && fcn_q == 6'h02;
  assign is_shift = r_type && (fcn_q inside {6'h00, 6'h02, 6'h06});
  assign is_imm   = op_q inside {6'h08, 6'h0D, 6'h23, 6'h2B};
  assign legal    = (op_i == 6'h00) ? (fcn_i inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h06}) :
                    (op_i == 6'h1C) ? (fcn_i inside {6'h21, 6'h20, 6'h02}) :
                    (op_i inside {6'h08, 6'h0D, 6'h23, 6'h2B, 6'h05});
  assign alu_op_dec = r_type ? (fcn_q == 6'h22 ? 4'h1 : fcn_q == 6'h24 ? 4'h2 : fcn_q == 6'h25 ? 4'h3 :
                                fcn_q == 6'h2A ? 4'h4 : fcn_q == 6'h00 ? 4'h5 : fcn_q == 6'h02 ? 4'h6 :
                                fcn_q == 6'h06 ? 4'h7 : 4'h0) :
                      s_type ? (fcn_q == 6'h21 ? 4'h8 : fcn_q == 6'h20 ? 4'h9 : 4'hA) :
                      op_q == 6'h0D ? 4'h3 : is_bne ? 4'h1 : 4'h0;
  // The MEM_TIMEOUT-th waiting cycle is the last chance; MemReady there still succeeds
  assign tmo_hit = tmo_q == TW'(MEM_TIMEOUT - 1);
  assign done_st = run_i ? FETCH : IDLE;
  assign ctl_en  = state_q inside {EXEC, MULWAIT, MEM, WB};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      fcn_q   <= '0;
      tmo_q   <= '0;
      mul_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fcn_q   <= fcn_d;
      tmo_q   <= tmo_d;
      mul_q   <= mul_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fcn_d   = fcn_q;
    tmo_d   = '0;
    mul_d   = mul_q;
    err_d   = err_q;
    case (state_q)
      IDLE:    state_d = (run_i && !err_q) ? FETCH : IDLE;
      FETCH, MEM: begin
        if (mem_ready_i) state_d = (state_q == FETCH) ? DECODE : is_sw ? done_st : WB;
        else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else tmo_d = tmo_q + TW'(1);
      end
      DECODE: begin
        op_d    = op_i;
        fcn_d   = fcn_i;
        err_d   = err_q | ~legal;
        state_d = legal ? EXEC : IDLE;
      end
      EXEC: begin
        state_d = (is_mul && MUL_CYCLES > 1) ? MULWAIT : is_bne ? done_st : (is_lw || is_sw) ? MEM : WB;
        mul_d   = MW'(MUL_CYCLES - 1);
      end
      MULWAIT: begin
        state_d = (mul_q == MW'(1)) ? WB : MULWAIT;
        mul_d   = mul_q - MW'(1);
      end
      WB:      state_d = done_st;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_src_o    = ctl_en && is_imm;
    alu_src2_o   = ctl_en && is_shift;
    reg_sl_o     = ctl_en && is_shift;
    reg_dst_o    = ctl_en && (r_type || s_type);
    alu_op_o     = ctl_en ? alu_op_dec : 4'h0;
    mem_to_reg_o = ctl_en && is_lw;
    reg_write_o  = state_q == WB;
    mem_read_o   = state_q == FETCH || (state_q == MEM && is_lw);
    mem_write_o  = state_q == MEM && is_sw;
    brnch_o      = state_q == EXEC && is_bne;
    ir_write_o   = state_q == FETCH && mem_ready_i;
    pc_write_o   = (state_q == FETCH && mem_ready_i) || (state_q == EXEC && is_bne && !zero_i);
    busy_o       = state_q != IDLE;
    err_o        = err_q;
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction streams checked cycle by cycle against a table-driven trace model
module tb_multicycle_controller;
  localparam int MT = 15;
  localparam logic [2:0] K_ALU = 3'd0, K_LW = 3'd1, K_SW = 3'd2, K_BNE = 3'd3, K_MUL = 3'd4;

  typedef struct packed {
    logic       alu_src, alu_src2, reg_sl, reg_dst, reg_write;
    logic [3:0] alu_op;
    logic       mem_read, mem_write, mem_to_reg, brnch, pc_write, ir_write, busy, err;
  } out_t;

  typedef struct packed {
    logic [5:0] op, fcn;
    logic [3:0] aop;
    logic       src, src2, dst;
    logic [2:0] kind;
  } ins_t;

  typedef struct {
    logic       run, rdy, z;
    logic [5:0] op, fcn;
    out_t       exp;
    string      tag;
  } ent_t;

  ins_t tab [16] = '{
    '{6'h00, 6'h20, 4'h0, 1'b0, 1'b0, 1'b1, K_ALU}, '{6'h00, 6'h22, 4'h1, 1'b0, 1'b0, 1'b1, K_ALU},
    '{6'h00, 6'h24, 4'h2, 1'b0, 1'b0, 1'b1, K_ALU}, '{6'h00, 6'h25, 4'h3, 1'b0, 1'b0, 1'b1, K_ALU},
    '{6'h00, 6'h2A, 4'h4, 1'b0, 1'b0, 1'b1, K_ALU}, '{6'h00, 6'h00, 4'h5, 1'b0, 1'b1, 1'b1, K_ALU},
    '{6'h00, 6'h02, 4'h6, 1'b0, 1'b1, 1'b1, K_ALU}, '{6'h00, 6'h06, 4'h7, 1'b0, 1'b1, 1'b1, K_ALU},
    '{6'h1C, 6'h21, 4'h8, 1'b0, 1'b0, 1'b1, K_ALU}, '{6'h1C, 6'h20, 4'h9, 1'b0, 1'b0, 1'b1, K_ALU},
    '{6'h1C, 6'h02, 4'hA, 1'b0, 1'b0, 1'b1, K_MUL}, '{6'h08, 6'h00, 4'h0, 1'b1, 1'b0, 1'b0, K_ALU},
    '{6'h0D, 6'h00, 4'h3, 1'b1, 1'b0, 1'b0, K_ALU}, '{6'h23, 6'h00, 4'h0, 1'b1, 1'b0, 1'b0, K_LW},
    '{6'h2B, 6'h00, 4'h0, 1'b1, 1'b0, 1'b0, K_SW},  '{6'h05, 6'h00, 4'h1, 1'b0, 1'b0, 1'b0, K_BNE}
  };

  logic       clk, rst_n, run, zero, mem_ready;
  logic [5:0] op, fcn;
  logic [16:0] v [2];
  out_t       got;
  int         sel, mc, n_checks, n_errors;
  ent_t       q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       alu_src, alu_src2, reg_sl, reg_dst, reg_write;
    logic [3:0] alu_op;
    logic       mem_read, mem_write, mem_to_reg, brnch, pc_write, ir_write, busy, err;
    multicycle_controller #(.MUL_CYCLES(g == 0 ? 3 : 1), .MEM_TIMEOUT(MT)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .op_i(op), .fcn_i(fcn), .zero_i(zero),
      .mem_ready_i(mem_ready), .alu_src_o(alu_src), .alu_src2_o(alu_src2), .reg_sl_o(reg_sl),
      .reg_dst_o(reg_dst), .reg_write_o(reg_write), .alu_op_o(alu_op), .mem_read_o(mem_read),
      .mem_write_o(mem_write), .mem_to_reg_o(mem_to_reg), .brnch_o(brnch), .pc_write_o(pc_write),
      .ir_write_o(ir_write), .busy_o(busy), .err_o(err)
    );
    assign v[g] = {alu_src, alu_src2, reg_sl, reg_dst, reg_write, alu_op,
                   mem_read, mem_write, mem_to_reg, brnch, pc_write, ir_write, busy, err};
  end

  assign got = v[sel];

  task automatic check(input string tag, input out_t obs, input out_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s (mul_cycles=%0d t=%0t): got %h expected %h", tag, mc, $time, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic bit lookup(input logic [5:0] o, input logic [5:0] f, output ins_t d);
    d = '0;
    for (int i = 0; i < 16; i++)
      if (tab[i].op == o && ((o != 6'h00 && o != 6'h1C) || tab[i].fcn == f)) begin
        d = tab[i];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic push(input logic rn, input logic rdy, input logic z, input logic [5:0] o,
                      input logic [5:0] f, input out_t exp, input string tag);
    ent_t e;
    e.run = rn; e.rdy = rdy; e.z = z; e.op = o; e.fcn = f; e.exp = exp; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic play(input int n);
    ent_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      run = e.run; mem_ready = e.rdy; zero = e.z; op = e.op; fcn = e.fcn;
      @(negedge clk);
      check(e.tag, got, e.exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    q.delete();
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("reset", got, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(1'b1, rb(), rb(), 6'h00, 6'h00, '0, "idle_start");
  endtask

  // Expected per-cycle trace of one instruction, derived from its table entry and latencies
  task automatic build(input logic [5:0] o, input logic [5:0] f, input int lf, input int lm,
                       input logic zb, input logic rn, output bit err);
    ins_t d;
    out_t x, st;
    bit   ok;
    ok  = lookup(o, f, d);
    err = 1'b0;
    for (int i = 0; i < lf && i < MT; i++) begin
      x = '0; x.busy = 1'b1; x.mem_read = 1'b1;
      x.ir_write = (i == lf - 1); x.pc_write = (i == lf - 1);
      push(rn, i == lf - 1, rb(), o, f, x, "fetch");
    end
    if (lf > MT) begin err = 1'b1; return; end
    x = '0; x.busy = 1'b1;
    push(rn, rb(), rb(), o, f, x, "decode");
    if (!ok) begin err = 1'b1; return; end
    st = '0; st.busy = 1'b1; st.alu_src = d.src; st.alu_src2 = d.src2; st.reg_sl = d.src2;
    st.reg_dst = d.dst; st.alu_op = d.aop; st.mem_to_reg = (d.kind == K_LW);
    x = st;
    if (d.kind == K_BNE) begin x.brnch = 1'b1; x.pc_write = !zb; end
    push(rn, rb(), d.kind == K_BNE ? zb : rb(), o, f, x, "exec");
    if (d.kind == K_MUL)
      for (int i = 1; i < mc; i++) push(rn, rb(), rb(), o, f, st, "mulwait");
    if (d.kind == K_LW || d.kind == K_SW) begin
      for (int i = 0; i < lm && i < MT; i++) begin
        x = st; x.mem_read = (d.kind == K_LW); x.mem_write = (d.kind == K_SW);
        push(rn, i == lm - 1, rb(), o, f, x, "mem");
      end
      if (lm > MT) begin err = 1'b1; return; end
    end
    if (d.kind != K_SW && d.kind != K_BNE) begin
      x = st; x.reg_write = 1'b1;
      push(rn, rb(), rb(), o, f, x, "wb");
    end
    if (!rn) push(1'b1, rb(), rb(), o, f, '0, "idle_run0");
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int lf, input int lm,
                           input logic zb, input logic rn);
    bit   e;
    out_t stuck;
    build(o, f, lf, lm, zb, rn, e);
    if (e) begin
      stuck = '0; stuck.err = 1'b1;
      repeat (3) push(1'b1, rb(), rb(), o, f, stuck, "err_idle");
    end
    play(q.size());
    if (e) do_reset();
  endtask

  function automatic int pick_lat();
    int x;
    x = $urandom_range(19, 0);
    return x == 0 ? MT + 1 : x == 1 ? MT : $urandom_range(4, 1);
  endfunction

  task automatic random_instr();
    ins_t d;
    logic [5:0] o, f;
    if ($urandom_range(11, 0) == 0) begin
      o = 6'($urandom); f = 6'($urandom);
      if (lookup(o, f, d)) o = 6'h3F;
    end else begin
      d = tab[$urandom_range(15, 0)];
      o = d.op;
      f = (d.op == 6'h00 || d.op == 6'h1C) ? d.fcn : 6'($urandom);
    end
    run_instr(o, f, pick_lat(), pick_lat(), rb(), $urandom_range(4, 0) != 0);
  endtask

  initial begin
    ent_t e;
    bit   er;
    n_checks = 0; n_errors = 0; sel = 0; mc = 3;
    rst_n = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; op = '0; fcn = '0;
    for (int p = 0; p < 2; p++) begin
      sel = p;
      mc  = (p == 0) ? 3 : 1;
      do_reset();
      run_instr(6'h00, 6'h20, 1, 1, 1'b0, 1'b1);
      run_instr(6'h1C, 6'h02, 1, 1, 1'b0, 1'b1);
      run_instr(6'h23, 6'h11, 2, 4, 1'b0, 1'b1);
      run_instr(6'h2B, 6'h00, 1, 3, 1'b0, 1'b1);
      run_instr(6'h05, 6'h00, 1, 1, 1'b0, 1'b1);
      run_instr(6'h05, 6'h00, 1, 1, 1'b1, 1'b0);
      run_instr(6'h08, 6'h3F, MT, 1, 1'b0, 1'b1);
      run_instr(6'h23, 6'h00, 1, MT, 1'b0, 1'b1);
      run_instr(6'h3F, 6'h00, 1, 1, 1'b0, 1'b1);
      run_instr(6'h00, 6'h20, MT + 1, 1, 1'b0, 1'b1);
      run_instr(6'h2B, 6'h00, 1, MT + 1, 1'b0, 1'b1);
      for (int k = 0; k < 150; k++) random_instr();
    end
    do_reset();
    build(6'h23, 6'h00, 1, 10, 1'b0, 1'b1, er);
    play(6);
    e = q.pop_front();
    run = e.run; mem_ready = e.rdy; zero = e.z; op = e.op; fcn = e.fcn;
    #1 check("pre_rst_mem", got, e.exp);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_mem", got, '0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
